// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a show-ahead receive FIFO and sticky frame/overrun flags.
// All state is on the rising edge of clk; rst_n asynchronously returns everything to idle.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic           r_sync1;
  logic           r_sync2;
  state_t         r_state;
  logic [TW-1:0]  r_tcnt;
  logic [2:0]     r_bidx;
  logic [7:0]     r_shift;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           r_frame_err;
  logic           r_overrun;

  logic w_rxs;
  logic w_half_tick;
  logic w_bit_tick;
  logic w_stop_done;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_rxs       = r_sync2;
  assign w_half_tick = (r_tcnt == HALF_M1);
  assign w_bit_tick  = (r_tcnt == FULL_M1);
  assign w_stop_done = ena && (r_state == S_STOP) && w_bit_tick;
  assign w_stop_ok   = w_stop_done && w_rxs;
  assign w_stop_bad  = w_stop_done && !w_rxs;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_FULL);
  assign w_pop       = rd_en && !w_empty;
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign w_push      = w_stop_ok && (!w_full || rd_en);
  assign w_drop      = w_stop_ok && w_full && !rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
    end else if (!ena) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_bidx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tcnt <= '0;
          r_bidx <= '0;
          if (!w_rxs) r_state <= S_START;
        end
        S_START: begin
          if (w_half_tick) begin
            r_tcnt  <= '0;
            r_state <= w_rxs ? S_IDLE : S_DATA;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_tick) begin
            r_tcnt  <= '0;
            r_shift <= {w_rxs, r_shift[7:1]};
            r_bidx  <= r_bidx + 1'b1;
            if (r_bidx == 3'd7) r_state <= S_STOP;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_tick) begin
            r_tcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tcnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad | (r_frame_err & ~clr_err);
      r_overrun   <= w_drop     | (r_overrun   & ~clr_err);
    end
  end

  assign rd_data   = r_mem[r_rptr];
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame table plus hand sequences for timing, reset and full-FIFO corners.
// Received bytes are tracked in a scoreboard queue and checked as they are popped.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [7:0]  sb_q[$];

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int unsigned pops;
    int unsigned cnt;
    logic        fe;
    logic        ov;
  } vec_t;

  vec_t tbl[8];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .rx       (rx),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string nm, input int unsigned c, input logic fe, input logic ov);
    chk({nm, ".count"}, 32'(count), c);
    chk({nm, ".empty"}, 32'(empty), 32'(c == 0));
    chk({nm, ".full"},  32'(full),  32'(c == DEPTH));
    chk({nm, ".frame_err"}, 32'(frame_err), 32'(fe));
    chk({nm, ".overrun"},   32'(overrun),   32'(ov));
    if (sb_q.size() > 0) chk({nm, ".head"}, 32'(rd_data), 32'(sb_q[0]));
  endtask

  // Called at posedge+1; returns at posedge+1 after the full 10-bit frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic model);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    if (model && stop && sb_q.size() < DEPTH) sb_q.push_back(b);
  endtask

  task automatic pop_check(input string nm);
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got %0h expected none", nm, rd_data);
    end else begin
      chk(nm, 32'(rd_data), 32'(sb_q.pop_front()));
    end
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] b77;
    tbl[0] = '{8'h01, 1'b1, 0, 1, 1'b0, 1'b0};
    tbl[1] = '{8'h02, 1'b1, 0, 2, 1'b0, 1'b0};
    tbl[2] = '{8'h03, 1'b1, 0, 3, 1'b0, 1'b0};
    tbl[3] = '{8'h04, 1'b1, 0, 4, 1'b0, 1'b0};
    tbl[4] = '{8'h05, 1'b1, 4, 4, 1'b0, 1'b1};
    tbl[5] = '{8'h3C, 1'b0, 0, 0, 1'b1, 1'b1};
    tbl[6] = '{8'hFF, 1'b1, 0, 1, 1'b1, 1'b1};
    tbl[7] = '{8'h00, 1'b1, 2, 2, 1'b1, 1'b1};

    rst_n = 1'b0; ena = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rd_data", 32'(rd_data), 32'h00);
    chk_status("reset", 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Push lands exactly one cycle after the stop sample.
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        chk("a5.empty_before", 32'(empty), 32'h1);
        @(posedge clk);
        #1;
        chk("a5.empty_after", 32'(empty), 32'h0);
        chk("a5.count", 32'(count), 32'h1);
        chk("a5.rd_data", 32'(rd_data), 32'hA5);
      end
    join
    pop_check("a5.pop");
    chk_status("a5.drained", 0, 1'b0, 1'b0);

    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk_status("pop_empty", 0, 1'b0, 1'b0);

    for (int unsigned r = 0; r < 8; r++) begin
      send_frame(tbl[r].data, tbl[r].stop, 1'b1);
      chk_status($sformatf("row%0d", r), tbl[r].cnt, tbl[r].fe, tbl[r].ov);
      for (int unsigned p = 0; p < tbl[r].pops; p++) pop_check($sformatf("row%0d.pop%0d", r, p));
    end
    chk_status("table.end", 0, 1'b1, 1'b1);

    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk_status("clr_err", 0, 1'b0, 1'b0);

    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk_status("glitch", 0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1);
    chk_status("post_glitch", 1, 1'b0, 1'b0);
    pop_check("post_glitch.pop");

    ena = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0);
    ena = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_status("ena_off", 0, 1'b0, 1'b0);

    // Load a byte and a frame error, then reset during data bit 3.
    send_frame(8'h42, 1'b1, 1'b1);
    send_frame(8'h11, 1'b0, 1'b1);
    chk_status("pre_reset", 1, 1'b1, 1'b0);
    b77 = 8'h77;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rx = b77[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = b77[3];
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("midrst.rd_data", 32'(rd_data), 32'h00);
    chk_status("midrst", 0, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b1, 1'b1);
    chk("post_rst.rd_data", 32'(rd_data), 32'h5A);
    chk_status("post_rst", 1, 1'b0, 1'b0);
    pop_check("post_rst.pop");

    for (int unsigned k = 0; k < 4; k++) send_frame(8'h10 + 8'(k), 1'b1, 1'b1);
    chk_status("fill", 4, 1'b0, 1'b0);
    fork
      send_frame(8'h14, 1'b1, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        rd_en = 1'b1;
        chk("full_pop.head", 32'(rd_data), 32'(sb_q.pop_front()));
        @(posedge clk);
        #1;
        rd_en = 1'b0;
      end
    join
    chk_status("full_pushpop", 4, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 4; k++) pop_check($sformatf("full_drain%0d", k));
    chk_status("final", 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
